fifo_read_adapter: RTL and testbench

FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

---
 rtl/fifo_read_adapter_pkg.sv | 18 +
 rtl/fifo_skid_buf.sv | 62 ++++++
 rtl/fifo_read_adapter.sv | 66 ++++++
 tb/tb_fifo_read_adapter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_adapter_pkg.sv
// Shared constants and occupancy type for the FIFO read adapter.
package fifo_read_adapter_pkg;

  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned RD_LATENCY = 1;

  typedef logic [1:0] occ_t;

  // True when occ + inflight - pop < BUF_DEPTH; compared without subtraction to avoid underflow.
  function automatic logic has_room(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] committed;
    logic [2:0] limit;
    committed = {1'b0, occ} + {2'b00, inflight};
    limit     = 3'(BUF_DEPTH) + {2'b00, pop};
    return committed < limit;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
module fifo_skid_buf
  import fifo_read_adapter_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DSIZE-1:0] din_i,
  input  logic             pop_i,
  output logic [DSIZE-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [DSIZE-1:0] ent0_q, ent0_d;
  logic [DSIZE-1:0] ent1_q, ent1_d;
  occ_t             occ_q, occ_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = din_i;
        else               ent1_d = din_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Capture and pop together: shift head out, new word lands behind any survivor.
        if (occ_q == 2'd1) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = ent0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_read_adapter.sv
// FIFO read port to valid/ready stream adapter with 1-cycle read latency.
// Packet framing (out_last) is built only when FIFO_READ_ADAPTER_LAST_EN is defined.
module fifo_read_adapter
  import fifo_read_adapter_pkg::*;
#(
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned PKT_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  logic       inflight_q, inflight_d;
  logic [1:0] occ;
  logic       pop;

  assign out_valid  = (occ != 2'd0);
  assign pop        = out_valid && out_ready;
  assign rinc       = rrst_n && !rempty && has_room(occ, inflight_q, pop);
  assign inflight_d = rinc;

  always_ff @(posedge rclk) begin
    if (!rrst_n) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  fifo_skid_buf #(
    .DSIZE (DSIZE)
  ) u_skid_buf (
    .clk_i  (rclk),
    .rst_ni (rrst_n),
    .push_i (inflight_q),
    .din_i  (rdata),
    .pop_i  (pop),
    .head_o (out_data),
    .occ_o  (occ)
  );

`ifdef FIFO_READ_ADAPTER_LAST_EN
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [15:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 16'd1;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) beat_q <= '0;
    else         beat_q <= beat_d;
  end

  assign out_last = out_valid && (beat_q == LAST_BEAT);
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Scoreboard bench for fifo_read_adapter with a behavioural 1-cycle-latency FIFO.
module tb_fifo_read_adapter;

  localparam int unsigned DW  = 8;
  localparam int unsigned PKT = 4;

  logic          rclk;
  logic          rrst_n;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          rinc;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  int            total;
  int            bad;
  int            delivered;
  int            lasts;
  int unsigned   beat;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_read_adapter #(
    .DSIZE   (DW),
    .PKT_LEN (PKT)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic exp_last(input int unsigned b);
`ifdef FIFO_READ_ADAPTER_LAST_EN
    return (b % PKT) == (PKT - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic neg();
    @(negedge rclk);
  endtask

  // Words with index below skip are loaded into the FIFO but not expected at the output.
  task automatic load(input logic [DW-1:0] base, input int n, input int skip);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      if (i >= skip) exp_q.push_back(base + DW'(i));
    end
    rempty = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  // FIFO model: a pop seen in one cycle presents its word for the whole next cycle.
  initial begin : fifo_model
    logic pop_n;
    forever begin
      @(negedge rclk);
      pop_n = rinc;
      if (pop_n) chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      @(posedge rclk);
      #1;
      if (pop_n && fifo_q.size() != 0) rdata = fifo_q.pop_front();
      rempty = (fifo_q.size() == 0);
    end
  end

  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        beat = 0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e));
        end
        chk("last", 32'(out_last), 32'(exp_last(beat)));
        if (out_last) lasts++;
        beat++;
        delivered++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : stimulus
    int cnt;
    int d0;
    int l0;
    total = 0; bad = 0; delivered = 0; lasts = 0; beat = 0;
    rrst_n = 1'b0; rempty = 1'b1; out_ready = 1'b0; rdata = '0;

    // Reset state, with rempty low to show rinc stays forced off.
    repeat (3) tick();
    rempty = 1'b0;
    neg();
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    tick();
    rrst_n = 1'b1;
    repeat (2) tick();

    // First-word latency and streaming throughput.
    out_ready = 1'b1;
    load(8'h11, 4, 0);
    neg(); chk("t1_rinc_c0", 32'(rinc), 32'd1);
    tick(); neg(); chk("t1_valid_c1", 32'(out_valid), 32'd0);
    tick(); neg(); chk("t1_valid_c2", 32'(out_valid), 32'd1);
    chk("t1_data_c2", 32'(out_data), 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick(); neg(); chk("t1_valid_stream", 32'(out_valid), 32'd1);
    end
    tick(); neg(); chk("t1_valid_c6", 32'(out_valid), 32'd0);
    drain("t1_drain", 20);

    // Backpressure: buffer fills to two words and pops stop.
    out_ready = 1'b0;
    load(8'h21, 5, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      neg();
      if (rinc) cnt++;
      if (i >= 2) begin
        chk("t2_valid_held", 32'(out_valid), 32'd1);
        chk("t2_data_held", 32'(out_data), 32'h21);
      end
      tick();
    end
    chk("t2_pop_count", 32'(cnt), 32'd2);
    neg(); chk("t2_rinc_full", 32'(rinc), 32'd0);
    tick();
    out_ready = 1'b1;
    drain("t2_drain", 40);

    // Toggling ready over ten words.
    d0 = delivered;
    load(8'h31, 10, 0);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    chk("t3_drain", 32'(exp_q.size()), 32'd0);
    chk("t3_count", 32'(delivered - d0), 32'd10);
    out_ready = 1'b1;
    repeat (3) tick();

    // FIFO goes empty while the last pop is still in flight.
    load(8'h41, 1, 0);
    neg(); chk("t4_rinc_c0", 32'(rinc), 32'd1);
    tick(); neg(); chk("t4_rinc_c1", 32'(rinc), 32'd0);
    tick(); neg(); chk("t4_valid_c2", 32'(out_valid), 32'd1);
    chk("t4_data_c2", 32'(out_data), 32'h41);
    tick(); neg(); chk("t4_valid_c3", 32'(out_valid), 32'd0);
    chk("t4_rinc_c3", 32'(rinc), 32'd0);
    tick();

    // Reset with one word buffered and one in flight; both are lost.
    out_ready = 1'b0;
    load(8'h51, 4, 2);
    neg(); tick(); neg(); tick();
    rrst_n = 1'b0;
    neg(); chk("t5_rinc_in_reset", 32'(rinc), 32'd0);
    tick();
    rrst_n = 1'b1;
    neg(); chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
    tick(); neg(); chk("t5_no_capture", 32'(out_valid), 32'd0);
    tick();
    out_ready = 1'b1;
    drain("t5_drain", 20);

    // Packet framing over eight beats after a fresh reset.
    rrst_n = 1'b0;
    tick();
    rrst_n = 1'b1;
    l0 = lasts;
    d0 = delivered;
    load(8'h61, 8, 0);
    drain("t6_drain", 30);
    chk("t6_count", 32'(delivered - d0), 32'd8);
`ifdef FIFO_READ_ADAPTER_LAST_EN
    chk("t6_last_count", 32'(lasts - l0), 32'd2);
`else
    chk("t6_last_count", 32'(lasts - l0), 32'd0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
